// File: rtl/spec_free_list_pkg.sv
// Shared rename-width constants and physical tag types for the free list and map tables.
// Purely declarative: no logic, no latency, no flow control.
package spec_free_list_pkg;

  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_RMT            = 32;
  localparam int FL_DEPTH            = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int FL_DEPTH_LOG        = 6;
  localparam int RENAME_WIDTH        = 4;

  typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_tag_t;
  typedef logic [FL_DEPTH_LOG-1:0]      fl_ptr_t;
  typedef logic [FL_DEPTH_LOG:0]        fl_cnt_t;
  typedef logic [2:0]                   slot_cnt_t;

endpackage

// File: rtl/spec_free_list_if.sv
// Rename/retire-side bundle of the free list; master drives requests, slave is the free list.
// FREE_LIST_STATS_EN adds the stall counter and low-water-mark outputs.
interface spec_free_list_if;
  import spec_free_list_pkg::*;

  logic      releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
  phys_tag_t releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i;
  logic      commitValid0_i, commitValid1_i, commitValid2_i, commitValid3_i;
  logic      reqFreeReg_i;
  logic      recoverFlag_i;
  phys_tag_t freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
  logic      freeListEmpty_o;
  fl_cnt_t   freeCnt_o;
`ifdef FREE_LIST_STATS_EN
  logic [31:0] stallCycles_o;
  fl_cnt_t     minFreeCnt_o;
`endif

  modport master (
`ifdef FREE_LIST_STATS_EN
    input  stallCycles_o, minFreeCnt_o,
`endif
    output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    output commitValid0_i, commitValid1_i, commitValid2_i, commitValid3_i,
    output reqFreeReg_i, recoverFlag_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeListEmpty_o, freeCnt_o
  );

  modport slave (
`ifdef FREE_LIST_STATS_EN
    output stallCycles_o, minFreeCnt_o,
`endif
    input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    input  commitValid0_i, commitValid1_i, commitValid2_i, commitValid3_i,
    input  reqFreeReg_i, recoverFlag_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeListEmpty_o, freeCnt_o
  );

endinterface

// File: rtl/spec_free_list_release_compactor.sv
// Packs valid slots (slot 0 first) into the low output positions and counts them.
// Combinational, zero latency, no flow control.
module spec_free_list_release_compactor
  import spec_free_list_pkg::*;
(
  input  logic [RENAME_WIDTH-1:0] valid_i,
  input  phys_tag_t               tag_i [RENAME_WIDTH],
  output phys_tag_t               tag_o [RENAME_WIDTH],
  output slot_cnt_t               count_o
);

  slot_cnt_t pos;

  always_comb begin
    pos = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) tag_o[k] = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (valid_i[k]) begin
        tag_o[pos[1:0]] = tag_i[k];
        pos             = pos + 3'd1;
      end
    end
    count_o = pos;
  end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: 4-wide release push, 4-wide allocate pop, one-cycle recovery to the commit head.
// Head tags are combinational reads; pops stall while freeListEmpty_o is high. FREE_LIST_STATS_EN adds stall/low-water stats.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  spec_free_list_if.slave fl
);

  phys_tag_t fl_q [FL_DEPTH];
  fl_ptr_t   head_q, head_d;
  fl_ptr_t   tail_q, tail_d;
  fl_ptr_t   commit_head_q, commit_head_d;
  fl_cnt_t   cnt_q, cnt_d;

  phys_tag_t rel_tags [RENAME_WIDTH];
  phys_tag_t push_tags [RENAME_WIDTH];
  phys_tag_t zero_tags [RENAME_WIDTH];
  phys_tag_t commit_tags_unused [RENAME_WIDTH];
  slot_cnt_t push_cnt, commit_cnt;
  logic      empty, pop;
  logic [FL_DEPTH_LOG+1:0] cnt_wide;

  assign rel_tags[0] = fl.releasedPhyMap0_i;
  assign rel_tags[1] = fl.releasedPhyMap1_i;
  assign rel_tags[2] = fl.releasedPhyMap2_i;
  assign rel_tags[3] = fl.releasedPhyMap3_i;
  assign zero_tags   = '{default: '0};

  spec_free_list_release_compactor u_release (
    .valid_i ({fl.releasedValid3_i, fl.releasedValid2_i, fl.releasedValid1_i, fl.releasedValid0_i}),
    .tag_i   (rel_tags),
    .tag_o   (push_tags),
    .count_o (push_cnt)
  );

  spec_free_list_release_compactor u_commit (
    .valid_i ({fl.commitValid3_i, fl.commitValid2_i, fl.commitValid1_i, fl.commitValid0_i}),
    .tag_i   (zero_tags),
    .tag_o   (commit_tags_unused),
    .count_o (commit_cnt)
  );

  // Empty looks only at the registered count, so same-cycle releases never unblock rename.
  assign empty = (cnt_q < fl_cnt_t'(RENAME_WIDTH)) || fl.recoverFlag_i;
  assign pop   = fl.reqFreeReg_i && !empty;

  always_comb begin
    commit_head_d = commit_head_q + fl_ptr_t'(commit_cnt);
    tail_d        = tail_q + fl_ptr_t'(push_cnt);
    cnt_wide      = {1'b0, cnt_q} + (FL_DEPTH_LOG+2)'(push_cnt)
                    - (pop ? (FL_DEPTH_LOG+2)'(RENAME_WIDTH) : '0);
    head_d        = pop ? head_q + fl_ptr_t'(RENAME_WIDTH) : head_q;
    cnt_d         = cnt_wide[FL_DEPTH_LOG:0];
    if (fl.recoverFlag_i) begin
      head_d = commit_head_d;
      cnt_d  = fl_cnt_t'(FL_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= phys_tag_t'(SIZE_RMT + i);
      head_q        <= '0;
      tail_q        <= '0;
      commit_head_q <= '0;
      cnt_q         <= fl_cnt_t'(FL_DEPTH);
    end else begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        if (3'(k) < push_cnt) fl_q[tail_q + fl_ptr_t'(k)] <= push_tags[k];
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      commit_head_q <= commit_head_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fl.freeReg0_o      = fl_q[head_q];
  assign fl.freeReg1_o      = fl_q[head_q + fl_ptr_t'(1)];
  assign fl.freeReg2_o      = fl_q[head_q + fl_ptr_t'(2)];
  assign fl.freeReg3_o      = fl_q[head_q + fl_ptr_t'(3)];
  assign fl.freeListEmpty_o = empty;
  assign fl.freeCnt_o       = cnt_q;

`ifdef FREE_LIST_STATS_EN
  logic [31:0] stall_q;
  fl_cnt_t     min_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      min_q   <= fl_cnt_t'(FL_DEPTH);
    end else begin
      if (fl.reqFreeReg_i && empty) stall_q <= stall_q + 32'd1;
      if (cnt_d < min_q) min_q <= cnt_d;
    end
  end

  assign fl.stallCycles_o = stall_q;
  assign fl.minFreeCnt_o  = min_q;
`endif

  // More tags released than were ever allocated means the retire side double-freed.
  assert property (@(posedge clk) disable iff (reset)
    !fl.recoverFlag_i |-> cnt_wide <= (FL_DEPTH_LOG+2)'(FL_DEPTH));

endmodule
